// File: rtl/pe_nin1out_pipe.sv
// pe_nin1out_pipe: generic N-to-1 compute node for the BDF fabric.
// Joins NUM_IN valid/ready channels, applies OR/AND/XOR/ADD chosen by op_sel,
// and carries each result through a LATENCY-stage elastic pipeline in which
// bubbles collapse and backpressure stalls only the full stages.
// Optional build macro: PE_STALL_CNT_EN adds a saturating 32-bit stall_cnt
// output that counts cycles with out_valid=1 and out_ready=0.
module pe_nin1out_pipe #(
  parameter  int WIDTH   = 16,
  parameter  int NUM_IN  = 2,
  parameter  int LATENCY = 15,
  localparam int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [1:0]              op_sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        occupancy
`ifdef PE_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } op_e;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [WIDTH-1:0]   data_d [LATENCY];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LATENCY:0]   adv;
  logic               fire;
  logic               pop;
  logic [WIDTH-1:0]   op_result;

  // Reduce all operands with the selected operation (ADD wraps, carry dropped).
  // NOTE: combinational blocks use blocking '=' so each loop iteration sees the
  // previous partial result; sequential blocks use '<=' only.
  always_comb begin
    logic [WIDTH-1:0] opnd;
    opnd      = '0;
    op_result = in_data[WIDTH-1:0];
    for (int i = 1; i < NUM_IN; i++) begin
      opnd = in_data[i*WIDTH +: WIDTH];
      case (op_e'(op_sel))
        OP_OR:   op_result = op_result | opnd;
        OP_AND:  op_result = op_result & opnd;
        OP_XOR:  op_result = op_result ^ opnd;
        default: op_result = op_result + opnd;
      endcase
    end
  end

  // Stage k may advance when the consumer pops or any stage at or after k is
  // empty; written out flat so no bit of adv depends on another.
  always_comb begin
    adv[LATENCY] = out_ready;
    for (int k = 0; k < LATENCY; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < LATENCY; j++) begin
        if (!vld_q[j]) adv[k] = 1'b1;
      end
    end
  end

  // All channels are consumed together; nothing is accepted while in reset.
  assign fire     = rst && (&in_valid) && adv[0];
  assign in_ready = {NUM_IN{fire}};
  assign pop      = vld_q[LATENCY-1] && out_ready;

  // Next state: shift every advancing stage, track occupancy.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv[0]) begin
      vld_d[0] = fire;
      if (fire) data_d[0] = op_result;
    end
    for (int k = 1; k < LATENCY; k++) begin
      if (adv[k]) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
    cnt_d = cnt_q;
    if (fire && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!fire && pop) cnt_d = cnt_q - 1'b1;
  end

  // Pipeline registers; reset drops every in-flight token at once.
  // NOTE: the data stages are reset as well because out_data must read 0 in
  // reset; that keeps them in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < LATENCY; k++) data_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];
  assign occupancy = cnt_q;

`ifdef PE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Count output stall cycles, saturating at all ones.
  always_comb begin
    stall_d = stall_q;
    if (vld_q[LATENCY-1] && !out_ready && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe_nin1out_pipe.sv
// tb_pe_nin1out_pipe: directed bench for pe_nin1out_pipe. A 2-input and a
// 4-input instance (both LATENCY=15) share clock and reset.
module tb_pe_nin1out_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [1:0]  in_valid2 = '0;
  logic [31:0] in_data2  = '0;
  logic [1:0]  in_ready2;
  logic [1:0]  op_sel2   = '0;
  logic        out_valid2;
  logic [15:0] out_data2;
  logic        out_ready2 = 1'b0;
  logic [3:0]  occ2;

  logic [3:0]  v4    = '0;
  logic [63:0] d4    = '0;
  logic [3:0]  r4;
  logic [1:0]  op4   = '0;
  logic        ov4;
  logic [15:0] od4;
  logic        ordy4 = 1'b0;
  logic [3:0]  occ4;

`ifdef PE_STALL_CNT_EN
  logic [31:0] stall_cnt2, stall_cnt4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int nxt, fires, exp_out, got;
  logic seen;
  logic [15:0] exp4 [4];

  always #5 clk = ~clk;

  pe_nin1out_pipe #(.WIDTH(16), .NUM_IN(2), .LATENCY(15)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_data   (in_data2),
    .in_ready  (in_ready2),
    .op_sel    (op_sel2),
    .out_valid (out_valid2),
    .out_data  (out_data2),
    .out_ready (out_ready2),
    .occupancy (occ2)
`ifdef PE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt2)
`endif
  );

  pe_nin1out_pipe #(.WIDTH(16), .NUM_IN(4), .LATENCY(15)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v4),
    .in_data   (d4),
    .in_ready  (r4),
    .op_sel    (op4),
    .out_valid (ov4),
    .out_data  (od4),
    .out_ready (ordy4),
    .occupancy (occ4)
`ifdef PE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state, with every channel valid to prove in_ready is held low
    in_valid2 = 2'b11;
    v4        = 4'hF;
    #2;
    check("rst_out_valid2", 32'(out_valid2), 32'd0);
    check("rst_out_data2",  32'(out_data2),  32'd0);
    check("rst_occ2",       32'(occ2),       32'd0);
    check("rst_in_ready2",  32'(in_ready2),  32'd0);
    check("rst_in_ready4",  32'(r4),         32'd0);
    check("rst_out_valid4", 32'(ov4),        32'd0);
    in_valid2 = '0;
    v4        = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    step();

    // ---- basic OR: 0x00F0 | 0x0F00 = 0x0FF0 after 15 cycles
    out_ready2 = 1'b1;
    op_sel2    = 2'd0;
    in_data2   = {16'h0F00, 16'h00F0};
    in_valid2  = 2'b11;
    #1 check("or_fire_ready", 32'(in_ready2), 32'h3);
    step();
    in_valid2 = '0;
    for (int i = 1; i <= 15; i++) begin
      check("or_occ", 32'(occ2), 32'd1);
      check("or_out_valid", 32'(out_valid2), (i == 15) ? 32'd1 : 32'd0);
      if (i == 15) check("or_out_data", 32'(out_data2), 32'h0FF0);
      step();
    end
    check("or_after_valid", 32'(out_valid2), 32'd0);
    check("or_after_occ",   32'(occ2),       32'd0);

    // ---- join: channel 1 late; no consumption until both valid
    op_sel2   = 2'd2;
    in_data2  = {16'h0005, 16'h0003};
    in_valid2 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1 check("join_wait_ready", 32'(in_ready2), 32'd0);
      step();
    end
    in_valid2 = 2'b11;
    #1 check("join_fire_ready", 32'(in_ready2), 32'h3);
    step();
    in_valid2 = '0;
    check("join_occ", 32'(occ2), 32'd1);
    repeat (14) step();
    check("join_out_valid", 32'(out_valid2), 32'd1);
    check("join_out_data",  32'(out_data2),  32'h0006);
    step();
    check("join_single_valid", 32'(out_valid2), 32'd0);
    check("join_single_occ",   32'(occ2),       32'd0);

    // ---- backpressure: 20 tokens 1..20, consumer stalled
    out_ready2 = 1'b0;
    op_sel2    = 2'd0;
    nxt        = 1;
    fires      = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid2 = 2'b11;
      in_data2  = {16'h0000, 16'(nxt)};
      #1;
      if (in_ready2 == 2'b11) begin
        fires++;
        nxt++;
      end
      step();
    end
    check("bp_fires", 32'(fires), 32'd15);
    check("bp_occ",   32'(occ2),  32'd15);
    #1 check("bp_in_ready", 32'(in_ready2), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_valid", 32'(out_valid2), 32'd1);
      check("bp_hold_data",  32'(out_data2),  32'd1);
      step();
    end

    // ---- release: full pipe pops and pushes in the same cycle, order kept
    out_ready2 = 1'b1;
    exp_out    = 1;
    for (int c = 0; c < 60 && exp_out <= 20; c++) begin
      if (nxt <= 20) begin
        in_valid2 = 2'b11;
        in_data2  = {16'h0000, 16'(nxt)};
      end else begin
        in_valid2 = '0;
      end
      #1;
      if (nxt <= 20) begin
        check("full_pushpop_occ",   32'(occ2),      32'd15);
        check("full_pushpop_ready", 32'(in_ready2), 32'h3);
      end
      if (in_valid2 == 2'b11 && in_ready2 == 2'b11) nxt++;
      if (out_valid2) begin
        check("drain_order", 32'(out_data2), 32'(exp_out));
        exp_out++;
      end
      step();
    end
    in_valid2 = '0;
    check("drain_count", 32'(exp_out), 32'd21);
    check("push_count",  32'(nxt),     32'd21);
    check("drain_occ",   32'(occ2),    32'd0);
    check("drain_valid", 32'(out_valid2), 32'd0);

    // ---- 4-input: ADD wraps, then AND/XOR/OR on following tokens, in order
    exp4[0] = 16'h0005;
    exp4[1] = 16'h0000;
    exp4[2] = 16'hFFFF;
    exp4[3] = 16'h1111;
    ordy4 = 1'b1;
    op4   = 2'd3;
    d4    = {16'h0003, 16'h0002, 16'h0001, 16'hFFFF};
    v4    = 4'hF;
    #1 check("add_fire_ready", 32'(r4), 32'hF);
    step();
    op4 = 2'd1;
    d4  = {16'hF0F0, 16'hFFFF, 16'h0FF0, 16'hFF00};
    step();
    op4 = 2'd2;
    d4  = {16'h8888, 16'h4444, 16'h2222, 16'h1111};
    step();
    op4 = 2'd0;
    d4  = {16'h1000, 16'h0100, 16'h0010, 16'h0001};
    step();
    v4  = '0;
    op4 = 2'd3;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (ov4) begin
        check("dut4_seq", 32'(od4), 32'(exp4[got]));
        got++;
      end
      step();
    end
    check("dut4_count", 32'(got),  32'd4);
    check("dut4_occ",   32'(occ4), 32'd0);

    // ---- output stall: token held 6 cycles at the output
    ordy4 = 1'b0;
    d4    = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    v4    = 4'hF;
    step();
    v4 = '0;
    for (int c = 0; c < 40 && !ov4; c++) step();
    check("stall_arrive", 32'(ov4), 32'd1);
    repeat (6) step();
    check("stall_hold_valid", 32'(ov4), 32'd1);
    check("stall_hold_data",  32'(od4), 32'h0004);
`ifdef PE_STALL_CNT_EN
    check("stall_cnt", stall_cnt4, 32'd6);
`endif
    ordy4 = 1'b1;
    step();
    check("stall_release", 32'(ov4), 32'd0);

    // ---- async reset mid-stream with 7 tokens in flight, one at the output
    out_ready2 = 1'b0;
    op_sel2    = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      in_valid2 = 2'b11;
      in_data2  = {16'h0000, 16'(k)};
      step();
    end
    in_valid2 = '0;
    repeat (10) step();
    check("pre_rst_occ",   32'(occ2),       32'd7);
    check("pre_rst_valid", 32'(out_valid2), 32'd1);
    #3 rst = 1'b0;
    in_valid2 = 2'b11;
    #1;
    check("mid_rst_valid",    32'(out_valid2), 32'd0);
    check("mid_rst_occ",      32'(occ2),       32'd0);
    check("mid_rst_data",     32'(out_data2),  32'd0);
    check("mid_rst_in_ready", 32'(in_ready2),  32'd0);
`ifdef PE_STALL_CNT_EN
    check("mid_rst_stall_cnt", stall_cnt2, 32'd0);
`endif
    in_valid2 = '0;
    #2 rst = 1'b1;
    out_ready2 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid2) seen = 1'b1;
    end
    check("post_rst_no_output", 32'(seen), 32'd0);
    op_sel2   = 2'd3;
    in_data2  = {16'h1234, 16'h0000};
    in_valid2 = 2'b11;
    step();
    in_valid2 = '0;
    check("post_rst_occ", 32'(occ2), 32'd1);
    repeat (14) step();
    check("post_rst_valid", 32'(out_valid2), 32'd1);
    check("post_rst_data",  32'(out_data2),  32'h1234);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_nin1out_pipe.md
Name: pe_nin1out_pipe

Overview:
- Parametrised successor to the fixed 2-input OR processing element: joins NUM_IN input channels, applies a runtime-selected bitwise/arithmetic op, and carries the result through a LATENCY-stage elastic pipeline.
- Every channel uses a valid/ready handshake, and each stage holds its own valid bit, so backpressure stalls only the full stages and bubbles collapse.
- Sits between dataflow token sources and consumers in the BDF fabric as the generic N-to-1 compute node.

Parameters:
- WIDTH, 16, data width of every channel.
- NUM_IN, 2, number of input channels joined; legal range 2..8.
- LATENCY, 15, pipeline stages from fire to out_valid; legal range 1..32.
- CNT_W, $clog2(LATENCY+1), width of the occupancy output (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset), deassert synchronised externally.
- in_valid  input  NUM_IN  per-channel token valid.
- in_data  input  NUM_IN x WIDTH  per-channel operand.
- in_ready  output  NUM_IN  per-channel accept.
- op_sel  input  2  operation: 0 OR, 1 AND, 2 XOR, 3 ADD.
- out_valid  output  1  result token valid.
- out_data  output  WIDTH  result.
- out_ready  input  1  consumer accept.
- occupancy  output  CNT_W  tokens currently held in the pipeline.

Behaviour:
- Reset (rst=0, asynchronous):
  - all stage valid bits = 0, all stage data = 0, occupancy = 0;
  - out_valid = 0, out_data = 0, in_ready = all 0.
- Stage structure:
  - stage k (0..LATENCY-1) holds {vld_k, data_k}.
  - adv_k = !vld_k || adv_{k+1}; adv_LATENCY = out_ready.
  - when adv_k, stage k loads stage k-1 (stage 0 loads the op result).
  - a stage with vld=0 always accepts, so bubbles collapse.
- Fire:
  - fire = &in_valid && adv_0; in_ready[i] = fire for every i. All channels are consumed together; no partial consumption.
  - in_ready depends combinationally on in_valid and out_ready. Sources must not make valid depend on ready.
- Operation:
  - op_sel is sampled at fire; each token carries its own result, so a mid-stream op_sel change affects only later tokens.
  - OR/AND/XOR: reduced over all NUM_IN operands.
  - ADD: sum of all operands modulo 2^WIDTH; carry is discarded.
- Output: out_valid = vld_{LATENCY-1}, out_data = data_{LATENCY-1}. Both are registered, with no combinational path from inputs.
- Latency:
  - with out_ready held 1, a token fired at cycle t shows out_valid at t+LATENCY;
  - throughput is 1 token/cycle.
- Stall:
  - out_valid=1 with out_ready=0 holds out_data stable;
  - upstream stages keep filling until full, then in_ready=0;
  - LATENCY tokens can be buffered.
- Occupancy:
  - +1 on fire, -1 on out_valid&&out_ready, unchanged when both happen in the same cycle;
  - never exceeds LATENCY;
  - equals the popcount of stage valid bits.
- Full pipeline with out_ready=1: output pops and fire succeeds in the same cycle; occupancy stays LATENCY.
- Reset mid-operation: all in-flight tokens are dropped immediately; no token is emitted after rst deasserts until a new fire.

Optional Feature:
- Macro: PE_STALL_CNT_EN.
- When defined:
  - adds output stall_cnt, 32 bits;
  - increments each cycle with out_valid=1 && out_ready=0, saturating at 0xFFFFFFFF;
  - clears to 0 on reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic OR, NUM_IN=2, LATENCY=15: in_data={0x00F0,0x0F00}, op_sel=0, fire at cycle 10, out_ready=1 -> out_valid=1 at cycle 25 with out_data=0x0FF0; occupancy 1 during cycles 11..25.
- ADD wrap, NUM_IN=4, WIDTH=16: operands {0xFFFF,0x0001,0x0002,0x0003} -> out_data=0x0005. Back-to-back op_sel 3 then 1 on the next token {0xFF00,0x0FF0,0xFFFF,0xF0F0} -> out_data=0x0000, in order.
- Backpressure: stream 20 tokens (values 1..20), out_ready=0 from start -> in_ready drops after 15 fires, occupancy=15, out_data=1 held. Release out_ready -> tokens 1..20 emerge in order with no loss or duplication.
- Join: channel 0 valid at cycle 5, channel 1 valid at cycle 9 -> in_ready all 0 until cycle 9, single fire at cycle 9.
- Simultaneous pop/push at full: occupancy=15, out_ready=1, all in_valid=1 -> occupancy stays 15 and one token per cycle passes.
- Async reset mid-stream: assert rst=0 between clock edges with occupancy=7 -> out_valid=0 and occupancy=0 immediately; no output until a new fire after release.
- With PE_STALL_CNT_EN: 6 stalled cycles -> stall_cnt=6.
